// File: rtl/shift_sched_pkg.sv
// Shared types and default sizes for the shift/ALU scheduler.
package shift_sched_pkg;

  localparam int WIDTH_DEF = 9;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_ASHR = 3'd2,
    OP_NOT  = 3'd3,
    OP_OR   = 3'd4,
    OP_ADD  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sched_if.sv
// Two-requester request/grant bundle between the requesters and shift_sched.
interface shift_sched_if import shift_sched_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [1:0]         req;
  logic [5:0]         op;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [2*CNT_W-1:0] cnt;
  logic [1:0]         gnt;
  logic               busy;
  logic [1:0]         done;
  logic [WIDTH-1:0]   result;
  logic               err;

  modport master (
    output req, op, a, b, cnt,
    input  gnt, busy, done, result, err
  );

  modport slave (
    input  req, op, a, b, cnt,
    output gnt, busy, done, result, err
  );
endinterface

// File: rtl/shift_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the winner on each advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // last_reg = 1 after reset so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_reg <= grant[1];
    end
  end
endmodule

// File: rtl/shift_sched.sv
// Arbitrates two requesters and applies one op repeatedly to a working register.
module shift_sched import shift_sched_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  shift_sched_if.slave bus
);
  state_e           state_reg, state_next;
  op_e              op_reg;
  logic [WIDTH-1:0] r_reg, b_reg;
  logic [CNT_W-1:0] count_reg;
  logic [1:0]       gnt_reg;
  logic             err_reg;
  logic [1:0]       arb_grant;
  logic             load, sel, busy_sig;
  logic [1:0]       done_sig;

  logic [2:0]       op_arr  [2];
  logic [WIDTH-1:0] a_arr   [2];
  logic [WIDTH-1:0] b_arr   [2];
  logic [CNT_W-1:0] cnt_arr [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_split
    assign op_arr[gi]  = bus.op[gi*3 +: 3];
    assign a_arr[gi]   = bus.a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]   = bus.b[gi*WIDTH +: WIDTH];
    assign cnt_arr[gi] = bus.cnt[gi*CNT_W +: CNT_W];
  end

  function automatic logic [WIDTH-1:0] apply_op(op_e o, logic [WIDTH-1:0] r,
                                                logic [WIDTH-1:0] bv);
    case (o)
      OP_SHL:  return r << 1;
      OP_SHR:  return r >> 1;
      OP_ASHR: return {r[WIDTH-1], r[WIDTH-1:1]};
      OP_NOT:  return ~r;
      OP_OR:   return r | bv;
      OP_ADD:  return r + bv;
      default: return r;
    endcase
  endfunction

  assign load = (state_reg == ST_IDLE) && (bus.req != 2'b00);
  assign sel  = arb_grant[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .advance (load),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_sig   = 1'b1;
    done_sig   = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        busy_sig = 1'b0;
        if (bus.req != 2'b00) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (count_reg == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_sig   = gnt_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Inputs are only looked at on LOAD; everything after works on captured copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_reg   <= 2'b00;
      op_reg    <= OP_SHL;
      r_reg     <= '0;
      b_reg     <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (load) begin
      gnt_reg   <= arb_grant;
      op_reg    <= op_e'(op_arr[sel]);
      r_reg     <= a_arr[sel];
      b_reg     <= b_arr[sel];
      count_reg <= cnt_arr[sel];
      err_reg   <= (op_arr[sel] > 3'd5);
    end else if ((state_reg == ST_RUN) && (count_reg != '0)) begin
      r_reg     <= apply_op(op_reg, r_reg, b_reg);
      count_reg <= count_reg - CNT_W'(1);
    end else if (state_reg == ST_DONE) begin
      gnt_reg   <= 2'b00;
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.busy   = busy_sig;
  assign bus.done   = done_sig;
  assign bus.result = r_reg;
  assign bus.err    = err_reg;
endmodule
